// File: rtl/lcd_if_pkg.sv
// Shared types, LCD command bytes and default timing for the character-LCD interface.
// Timing values are in clk cycles at 50 MHz.
package lcd_if_pkg;

    typedef enum logic [3:0] {
        POWERON, INIT_3A, INIT_3B, INIT_3C, INIT_2,
        CFG, ADDR1, LINE1, ADDR2, LINE2
    } state_t;

    // Sub-steps of one transfer inside a sequencer state.
    typedef enum logic [2:0] {
        PH_HI, PH_HI_BUSY, PH_GAP, PH_LO, PH_LO_BUSY, PH_WAIT
    } phase_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD
    } tx_state_t;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] DDRAM_L1 = 8'h80;
    localparam logic [7:0] DDRAM_L2 = 8'hC0;

    localparam int DEF_T_POWERON = 750000;
    localparam int DEF_T_INIT1   = 205000;
    localparam int DEF_T_INIT2   = 5000;
    localparam int DEF_T_CMD     = 2000;
    localparam int DEF_T_CLEAR   = 82000;
    localparam int DEF_T_NIB     = 50;
    localparam int DEF_T_SETUP   = 2;
    localparam int DEF_T_EPULSE  = 12;
    localparam int DEF_T_HOLD    = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one 4-bit nibble onto the LCD bus: setup, E pulse, hold, then a one-cycle done.
// Data and RS are latched on start and held until the next start.
module lcd_nibble_tx
    import lcd_if_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_EPULSE = DEF_T_EPULSE,
    parameter int T_HOLD   = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       e,
    output logic [3:0] dataout,
    output logic       lcd_rs,
    output logic       done
);

    localparam int CW = $clog2(max_int(max_int(T_SETUP, T_EPULSE), T_HOLD) + 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        done    = 1'b0;
        case (state)
            TX_IDLE: begin
                cnt_n = '0;
                if (start) state_n = TX_SETUP;
            end
            TX_SETUP: if (cnt == CW'(T_SETUP - 1)) begin
                state_n = TX_PULSE;
                cnt_n   = '0;
            end
            TX_PULSE: if (cnt == CW'(T_EPULSE - 1)) begin
                state_n = TX_HOLD;
                cnt_n   = '0;
            end
            TX_HOLD: if (cnt == CW'(T_HOLD - 1)) begin
                state_n = TX_IDLE;
                cnt_n   = '0;
                done    = 1'b1;
            end
            default: begin
                state_n = TX_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            dataout <= 4'h0;
            lcd_rs  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == TX_IDLE && start) begin
                dataout <= nibble;
                lcd_rs  <= rs;
            end
        end
    end

    // Decoded from the state register so reset drops E without waiting for a clock.
    assign e = (state == TX_PULSE);

endmodule

// File: rtl/lcd_if.sv
// HD44780 4-bit LCD interface: 32-byte display buffer, power-on init and endless
// refresh of both lines from the buffer.
module lcd_if
    import lcd_if_pkg::*;
#(
    parameter int T_POWERON = DEF_T_POWERON,
    parameter int T_INIT1   = DEF_T_INIT1,
    parameter int T_INIT2   = DEF_T_INIT2,
    parameter int T_CMD     = DEF_T_CMD,
    parameter int T_CLEAR   = DEF_T_CLEAR,
    parameter int T_NIB     = DEF_T_NIB,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_EPULSE  = DEF_T_EPULSE,
    parameter int T_HOLD    = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] Din,
    input  logic       W,
    input  logic [5:0] WADD,
    output logic [3:0] dataout,
    output logic [2:0] control
);

    localparam int T_MAX = max_int(max_int(max_int(T_POWERON, T_INIT1), max_int(T_INIT2, T_CMD)),
                                   max_int(T_CLEAR, T_NIB));
    localparam int CNT_W = $clog2(T_MAX + 1);

    logic [7:0]       buffer [32];
    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [3:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n, wait_limit;
    logic [7:0]       byte_q, cur_byte;
    logic             is_char, nibble_only, latch;
    logic             tx_start, tx_rs, tx_done, lcd_e, lcd_rs;
    logic [3:0]       tx_nibble;

    // NOTE: the buffer must power up as spaces, so it is built from resettable flops, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
        end else if (W && !WADD[5]) begin
            buffer[WADD[4:0]] <= Din;
        end
    end

    assign is_char     = (state == LINE1) || (state == LINE2);
    assign nibble_only = (state == INIT_3A) || (state == INIT_3B) ||
                         (state == INIT_3C) || (state == INIT_2);

    always_comb begin
        cur_byte = 8'h20;
        case (state)
            INIT_3A, INIT_3B, INIT_3C: cur_byte = 8'h30;
            INIT_2:                    cur_byte = 8'h20;
            CFG: begin
                case (idx[1:0])
                    2'd0:    cur_byte = FUNC_SET;
                    2'd1:    cur_byte = ENTRY;
                    2'd2:    cur_byte = DISP_ON;
                    default: cur_byte = CLEAR;
                endcase
            end
            ADDR1:   cur_byte = DDRAM_L1;
            ADDR2:   cur_byte = DDRAM_L2;
            LINE1:   cur_byte = buffer[{1'b0, idx}];
            LINE2:   cur_byte = buffer[{1'b1, idx}];
            default: cur_byte = 8'h20;
        endcase
    end

    always_comb begin
        case (state)
            POWERON: wait_limit = CNT_W'(T_POWERON);
            INIT_3A: wait_limit = CNT_W'(T_INIT1);
            INIT_3B: wait_limit = CNT_W'(T_INIT2);
            CFG:     wait_limit = (byte_q == CLEAR) ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
            default: wait_limit = CNT_W'(T_CMD);
        endcase
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        idx_n     = idx;
        cnt_n     = cnt + 1'b1;
        latch     = 1'b0;
        tx_start  = 1'b0;
        tx_nibble = cur_byte[7:4];
        tx_rs     = is_char;
        case (phase)
            PH_HI: begin
                tx_start = 1'b1;
                latch    = 1'b1;
                cnt_n    = '0;
                phase_n  = PH_HI_BUSY;
            end
            PH_HI_BUSY: begin
                cnt_n = '0;
                if (tx_done) phase_n = nibble_only ? PH_WAIT : PH_GAP;
            end
            PH_GAP: if (cnt == CNT_W'(T_NIB - 1)) begin
                cnt_n   = '0;
                phase_n = PH_LO;
            end
            PH_LO: begin
                tx_start  = 1'b1;
                tx_nibble = byte_q[3:0];
                cnt_n     = '0;
                phase_n   = PH_LO_BUSY;
            end
            PH_LO_BUSY: begin
                cnt_n = '0;
                if (tx_done) phase_n = PH_WAIT;
            end
            PH_WAIT: if (cnt == wait_limit - 1'b1) begin
                cnt_n   = '0;
                phase_n = PH_HI;
                idx_n   = '0;
                case (state)
                    POWERON: state_n = INIT_3A;
                    INIT_3A: state_n = INIT_3B;
                    INIT_3B: state_n = INIT_3C;
                    INIT_3C: state_n = INIT_2;
                    INIT_2:  state_n = CFG;
                    CFG: begin
                        if (idx == 4'd3) state_n = ADDR1;
                        else             idx_n   = idx + 4'd1;
                    end
                    ADDR1: state_n = LINE1;
                    LINE1: begin
                        if (idx == 4'd15) state_n = ADDR2;
                        else              idx_n   = idx + 4'd1;
                    end
                    ADDR2: state_n = LINE2;
                    LINE2: begin
                        if (idx == 4'd15) state_n = ADDR1;
                        else              idx_n   = idx + 4'd1;
                    end
                    default: state_n = POWERON;
                endcase
            end
            default: begin
                cnt_n   = '0;
                phase_n = PH_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= POWERON;
            phase  <= PH_WAIT;
            idx    <= '0;
            cnt    <= '0;
            byte_q <= 8'h00;
        end else begin
            state <= state_n;
            phase <= phase_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            if (latch) byte_q <= cur_byte;
        end
    end

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_EPULSE(T_EPULSE),
        .T_HOLD  (T_HOLD)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tx_start),
        .nibble (tx_nibble),
        .rs     (tx_rs),
        .e      (lcd_e),
        .dataout(dataout),
        .lcd_rs (lcd_rs),
        .done   (tx_done)
    );

    assign control = {lcd_e, lcd_rs, 1'b0};

endmodule

// File: tb/tb_lcd_if.sv
// Self-checking bench for lcd_if with reduced timing: a monitor captures every E pulse
// and compares it with a queue of expected {RS, nibble} values pushed by the stimulus.
module tb_lcd_if;

    localparam int TP_POWERON = 20;
    localparam int TP_INIT1   = 10;
    localparam int TP_INIT2   = 6;
    localparam int TP_CMD     = 5;
    localparam int TP_CLEAR   = 8;
    localparam int TP_NIB     = 3;
    localparam int TP_SETUP   = 2;
    localparam int TP_EPULSE  = 4;
    localparam int TP_HOLD    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:7] din;
    logic       w;
    logic [5:0] wadd;
    logic [3:0] dataout;
    logic [2:0] control;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q [$];
    logic [7:0] model_buf [32];

    logic       mon_prev_e = 1'b0;
    logic       mon_rw_seen = 1'b0;
    int         mon_width = 0;
    int         nib_idx = 0;
    logic [4:0] mon_exp;
    logic [4:0] mon_obs;

    lcd_if #(
        .T_POWERON(TP_POWERON), .T_INIT1(TP_INIT1), .T_INIT2(TP_INIT2),
        .T_CMD(TP_CMD), .T_CLEAR(TP_CLEAR), .T_NIB(TP_NIB),
        .T_SETUP(TP_SETUP), .T_EPULSE(TP_EPULSE), .T_HOLD(TP_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Din    (din),
        .W      (w),
        .WADD   (wadd),
        .dataout(dataout),
        .control(control)
    );

    always #5 clk = ~clk;

    // Pulse monitor: widths, RW, and the scoreboard comparison at each E falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_e  = 1'b0;
            mon_width   = 0;
            mon_rw_seen = 1'b0;
        end else begin
            if (control[2]) begin
                mon_width++;
                if (control[0]) mon_rw_seen = 1'b1;
            end
            if (mon_prev_e && !control[2]) begin
                checks++;
                assert (mon_width === TP_EPULSE) else begin
                    failures++;
                    $error("FAIL e_width got %0d exp %0d", mon_width, TP_EPULSE);
                end
                checks++;
                assert (mon_rw_seen === 1'b0) else begin
                    failures++;
                    $error("FAIL lcd_rw got 1 exp 0");
                end
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    mon_obs = {control[1], dataout};
                    checks++;
                    assert (mon_obs === mon_exp) else begin
                        failures++;
                        $error("FAIL nibble[%0d] got rs/nib %h exp %h", nib_idx, mon_obs, mon_exp);
                    end
                    nib_idx++;
                end
                mon_width   = 0;
                mon_rw_seen = 1'b0;
            end
            mon_prev_e = control[2];
        end
    end

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_pass();
        push_byte(1'b0, 8'h80);
        for (int c = 0; c < 16; c++) push_byte(1'b1, model_buf[c]);
        push_byte(1'b0, 8'hC0);
        for (int c = 16; c < 32; c++) push_byte(1'b1, model_buf[c]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [7:0] d);
        if (!a[5]) model_buf[a[4:0]] = d;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        w    = 1'b1;
        wadd = a;
        din  = d;
        @(negedge clk);
        w = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (control === 3'b000) else begin
            failures++;
            $error("FAIL %s_control got %b exp 000", tag, control);
        end
        checks++;
        assert (dataout === 4'h0) else begin
            failures++;
            $error("FAIL %s_dataout got %h exp 0", tag, dataout);
        end
    endtask

    task automatic wait_first_e(input string tag);
        int n;
        n = 0;
        while (!control[2] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (control[2] === 1'b1 && n >= TP_POWERON) else begin
            failures++;
            $error("FAIL %s_first_e got %0d cycles exp >= %0d", tag, n, TP_POWERON);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain got %0d pending exp 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    logic [5:0] wr_addr [6];
    logic [7:0] wr_data [6];
    int         n_wait;

    initial begin
        wr_addr[0] = 6'h00; wr_data[0] = 8'h4C;
        wr_addr[1] = 6'h01; wr_data[1] = 8'h49;
        wr_addr[2] = 6'h02; wr_data[2] = 8'h4E;
        wr_addr[3] = 6'h03; wr_data[3] = 8'h49;
        wr_addr[4] = 6'h10; wr_data[4] = 8'h41;
        wr_addr[5] = 6'h20; wr_data[5] = 8'hFF;

        rst_n = 1'b0;
        w     = 1'b0;
        wadd  = 6'h00;
        din   = 8'h00;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Power-on: full init followed by a refresh pass of spaces.
        push_init();
        push_pass();
        rst_n = 1'b1;
        wait_first_e("poweron");
        wait_drain("pass1");

        // Host writes land on the next refresh pass; the WADD[5]=1 write is ignored.
        for (int i = 0; i < 6; i++) model_write(wr_addr[i], wr_data[i]);
        push_pass();
        for (int i = 0; i < 6; i++) host_write(wr_addr[i], wr_data[i]);
        wait_drain("pass2");

        // Reset in the middle of a LINE1 E-high window.
        n_wait = 0;
        while (!(control[2] && control[1]) && n_wait < 3000) begin
            @(negedge clk);
            n_wait++;
        end
        checks++;
        assert (control[2] === 1'b1 && control[1] === 1'b1) else begin
            failures++;
            $error("FAIL line1_e_window got %b exp 11x", control);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (control[2] === 1'b0) else begin
            failures++;
            $error("FAIL async_e_drop got %b exp 0", control[2]);
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");

        exp_q.delete();
        model_clear();
        push_init();
        push_pass();
        rst_n = 1'b1;
        wait_first_e("reinit");
        wait_drain("pass3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
